mux_nto1_pipe: RTL and testbench

Parametrised, registered N-to-1 selector. It is the successor to the datapath's plain 2:1 combinational muxes. Each of NCH producer channels offers a WIDTH-bit word under valid/ready. Each cycle one channel is granted, either by an explicit select or by round-robin. The granted word is captured into a one-entry output register that drives a valid/ready consumer. It sits between multi-source datapath stages, e.g. register-file write-back source or write-address selection, where the source must be held stable across stalls.

---
 rtl/mux_nto1_pipe_pkg.sv | 11 +
 rtl/rr_arbiter_nto1.sv | 30 +++
 rtl/mux_nto1_pipe.sv | 100 ++++++++++
 tb/tb_mux_nto1_pipe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux_nto1_pipe_pkg.sv
// Shared constants for the registered N-to-1 selector: mode encodings and default sizes.
// Round-robin support is enabled with the MUX_NTO1_PIPE_RR_EN macro.
package mux_nto1_pipe_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/rr_arbiter_nto1.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping modulo NCH.
// Instantiated by mux_nto1_pipe only when MUX_NTO1_PIPE_RR_EN is defined.
module rr_arbiter_nto1
  import mux_nto1_pipe_pkg::*;
#(
  parameter  int NCH  = DEF_NCH,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [SELW-1:0] c_idx;
    any   = 1'b0;
    idx   = '0;
    c_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      c_idx = SELW'((int'(ptr) + k) % NCH);
      if (req[c_idx]) begin
        any = 1'b1;
        idx = c_idx;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 selector with a one-entry output register under valid/ready.
// Define MUX_NTO1_PIPE_RR_EN to enable round-robin mode; otherwise mode is ignored.
module mux_nto1_pipe
  import mux_nto1_pipe_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_ch_reg;
  logic             can_load;
  logic             sel_ok;
  logic             fix_grant;
  logic             grant;
  logic [SELW-1:0]  gidx;
  logic             xfer;
  logic [WIDTH-1:0] words [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign words[gi]    = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = xfer && (gidx == SELW'(gi));
    end
  endgenerate

  assign can_load  = !out_valid_reg || out_ready;
  assign sel_ok    = (int'(sel) < NCH);
  assign fix_grant = sel_ok && in_valid[sel];

`ifdef MUX_NTO1_PIPE_RR_EN
  logic            use_rr;
  logic            rr_any;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] ptr_reg;

  rr_arbiter_nto1 #(.NCH(NCH)) u_arb (
    .req (in_valid),
    .ptr (ptr_reg),
    .any (rr_any),
    .idx (rr_idx)
  );

  assign use_rr = (mode == MODE_RR);
  assign grant  = use_rr ? rr_any : fix_grant;
  assign gidx   = use_rr ? rr_idx : sel;

  // Pointer only follows round-robin transfers; fixed-mode grants leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= SELW'(NCH - 1);
    end else if (xfer && use_rr) begin
      ptr_reg <= gidx;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign grant       = fix_grant;
  assign gidx        = sel;
`endif

  assign xfer = grant && can_load;

  // Drain without reload clears valid but keeps the last word and channel visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= words[gidx];
      out_ch_reg    <= gidx;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe (WIDTH=5, NCH=4); expectations follow MUX_NTO1_PIPE_RR_EN.
module tb_mux_nto1_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [19:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [4:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(5), .NCH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        m;
    logic [1:0]  s;
    logic [3:0]  iv;
    logic        ordy;
    logic [19:0] d;
    logic [3:0]  eir;
    logic        eov;
    logic [4:0]  ed;
    logic [1:0]  ech;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at post-edge time, check in_ready combinationally, then outputs after the edge.
  task automatic cycle(input logic m, input logic [1:0] s, input logic [3:0] iv, input logic ordy,
                       input logic [19:0] d, input logic [3:0] eir, input logic eov,
                       input logic [4:0] ed, input logic [1:0] ech, input string nm);
    mode = m; sel = s; in_valid = iv; out_ready = ordy; in_data = d;
    #1;
    check({nm, ".in_ready"}, 32'(in_ready), 32'(eir));
    @(posedge clk);
    #1;
    check({nm, ".out_valid"}, 32'(out_valid), 32'(eov));
    check({nm, ".out_data"}, 32'(out_data), 32'(ed));
    check({nm, ".out_ch"}, 32'(out_ch), 32'(ech));
    $display("%-10s mode=%0d sel=%0d iv=%b ordy=%0d -> in_ready=%b ov=%0d data=%h ch=%0d",
             nm, m, s, iv, ordy, in_ready, out_valid, out_data, out_ch);
  endtask

  initial begin
    logic [19:0] dd;
    logic [19:0] d2;
    dd = {5'h1C, 5'h15, 5'h07, 5'h11};
    d2 = {5'h1C, 5'h15, 5'h07, 5'h0A};

    tbl[0] = '{1'b0, 2'd2, 4'b0110, 1'b1, dd, 4'b0100, 1'b1, 5'h15, 2'd2};
    tbl[1] = '{1'b0, 2'd3, 4'b0110, 1'b1, dd, 4'b0000, 1'b0, 5'h15, 2'd2};
    tbl[2] = '{1'b0, 2'd0, 4'b0001, 1'b0, d2, 4'b0001, 1'b1, 5'h0A, 2'd0};
    tbl[3] = '{1'b1, 2'd1, 4'b1111, 1'b0, dd, 4'b0000, 1'b1, 5'h0A, 2'd0};
    tbl[4] = '{1'b0, 2'd2, 4'b1111, 1'b0, dd, 4'b0000, 1'b1, 5'h0A, 2'd0};
    tbl[5] = '{1'b0, 2'd3, 4'b1111, 1'b0, dd, 4'b0000, 1'b1, 5'h0A, 2'd0};
    tbl[6] = '{1'b0, 2'd1, 4'b1111, 1'b1, dd, 4'b0010, 1'b1, 5'h07, 2'd1};
    tbl[7] = '{1'b0, 2'd3, 4'b1000, 1'b1, dd, 4'b1000, 1'b1, 5'h1C, 2'd3};
    tbl[8] = '{1'b0, 2'd3, 4'b0000, 1'b1, dd, 4'b0000, 1'b0, 5'h1C, 2'd3};

    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = dd; out_ready = 1'b0;
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].m, tbl[i].s, tbl[i].iv, tbl[i].ordy, tbl[i].d,
            tbl[i].eir, tbl[i].eov, tbl[i].ed, tbl[i].ech, $sformatf("vec%0d", i));
    end

    // Asynchronous reset while a word is held
    cycle(1'b0, 2'd0, 4'b0001, 1'b0, dd, 4'b0001, 1'b1, 5'h11, 2'd0, "preRst");
    in_valid = 4'b1111; mode = 1'b1; sel = 2'd1; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.out_data", 32'(out_data), 32'd0);
    check("arst.out_ch", 32'(out_ch), 32'd0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef MUX_NTO1_PIPE_RR_EN
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 2'd1, 4'b1111, 1'b1, dd, 4'(1 << (k % 4)), 1'b1,
            dd[(k % 4) * 5 +: 5], 2'(k % 4), $sformatf("rrFair%0d", k));
    end
    cycle(1'b1, 2'd1, 4'b0100, 1'b1, dd, 4'b0100, 1'b1, 5'h15, 2'd2, "rrTo2");
    cycle(1'b1, 2'd1, 4'b0011, 1'b1, dd, 4'b0001, 1'b1, 5'h11, 2'd0, "rrWrap0");
    cycle(1'b1, 2'd1, 4'b0011, 1'b1, dd, 4'b0010, 1'b1, 5'h07, 2'd1, "rrWrap1");
    cycle(1'b0, 2'd2, 4'b0100, 1'b1, dd, 4'b0100, 1'b1, 5'h15, 2'd2, "fixNoPtr");
    cycle(1'b1, 2'd1, 4'b1111, 1'b1, dd, 4'b0100, 1'b1, 5'h15, 2'd2, "rrPtrKept");
    cycle(1'b1, 2'd1, 4'b1111, 1'b1, dd, 4'b1000, 1'b1, 5'h1C, 2'd3, "rrNext3");
    cycle(1'b1, 2'd1, 4'b1101, 1'b1, dd, 4'b0001, 1'b1, 5'h11, 2'd0, "rrNext0");
    cycle(1'b1, 2'd1, 4'b1101, 1'b1, dd, 4'b0100, 1'b1, 5'h15, 2'd2, "rrSkip1");
`else
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 2'd1, 4'b1111, 1'b1, dd, 4'b0010, 1'b1, 5'h07, 2'd1, $sformatf("noRr%0d", k));
    end
    cycle(1'b1, 2'd1, 4'b0100, 1'b1, dd, 4'b0000, 1'b0, 5'h07, 2'd1, "noRrIdle");
    cycle(1'b1, 2'd1, 4'b0011, 1'b1, dd, 4'b0010, 1'b1, 5'h07, 2'd1, "noRrSel1");
    cycle(1'b1, 2'd1, 4'b1101, 1'b1, dd, 4'b0000, 1'b0, 5'h07, 2'd1, "noRrDrop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
